// File: rtl/gpio_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : gpio_port_ctrl_if
// Brief   : Bus/pad-side signal bundle for the multi-pin GPIO port controller.
// Revision: 1.0 - initial release
// ============================================================================
interface gpio_port_ctrl_if #(
   parameter int WIDTH = 8
);
   logic [2*WIDTH-1:0] fun;
   logic               out_wr;
   logic [WIDTH-1:0]   out_wdata;
   logic [WIDTH-1:0]   out_data;
   logic [WIDTH-1:0]   in_data;
   logic [WIDTH-1:0]   pad_in;
   logic [WIDTH-1:0]   pad_out;
   logic [WIDTH-1:0]   pad_oe;
   logic [WIDTH-1:0]   alt_out;
   logic [WIDTH-1:0]   alt_in;
   logic [2*WIDTH-1:0] irq_mode;
   logic [WIDTH-1:0]   irq_clr;
   logic [WIDTH-1:0]   irq_pending;
   logic               irq;

   modport slave (
      input  fun, out_wr, out_wdata, pad_in, alt_out, irq_mode, irq_clr,
      output out_data, in_data, pad_out, pad_oe, alt_in, irq_pending, irq
   );

   modport master (
      output fun, out_wr, out_wdata, pad_in, alt_out, irq_mode, irq_clr,
      input  out_data, in_data, pad_out, pad_oe, alt_in, irq_pending, irq
   );
endinterface
`default_nettype wire

// File: rtl/gpio_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gpio_port_ctrl
// Brief   : Multi-pin GPIO port: sync + debounce, output register, pad/alt
//           function mux and per-pin edge interrupts with W1C pending bits.
// Revision: 1.0 - initial release
// ============================================================================
module gpio_port_ctrl #(
   parameter int   WIDTH      = 8,
   parameter int   DEB_CYCLES = 4,
   parameter logic INIT_LEVEL = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   gpio_port_ctrl_if.slave bus
);

   localparam int              c_cnt_w   = $clog2(DEB_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

   logic [WIDTH-1:0]   s1_q,   s1_d;
   logic [WIDTH-1:0]   s2_q,   s2_d;
   logic [WIDTH-1:0]   filt_q, filt_d;
   logic [WIDTH-1:0]   pend_q, pend_d;
   logic [WIDTH-1:0]   out_q,  out_d;
   logic [c_cnt_w-1:0] cnt_q [WIDTH];
   logic [c_cnt_w-1:0] cnt_d [WIDTH];

   always_comb begin
      s1_d   = bus.pad_in;
      s2_d   = s1_q;
      filt_d = filt_q;
      // Clear is applied first so a same-cycle set overrides it.
      pend_d = pend_q & ~bus.irq_clr;
      out_d  = bus.out_wr ? bus.out_wdata : out_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == c_cnt_max) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = '0;
            // fun 0 and 2 are the input-type functions (bit 0 clear).
            if (!bus.fun[2*i]) begin
               if ((s2_q[i] && bus.irq_mode[2*i]) || (!s2_q[i] && bus.irq_mode[2*i+1]))
                  pend_d[i] = 1'b1;
            end
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= {WIDTH{INIT_LEVEL}};
         s2_q   <= {WIDTH{INIT_LEVEL}};
         filt_q <= {WIDTH{INIT_LEVEL}};
         pend_q <= '0;
         out_q  <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         filt_q <= filt_d;
         pend_q <= pend_d;
         out_q  <= out_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      bus.pad_oe  = '0;
      bus.pad_out = '0;
      bus.alt_in  = '1;
      for (int i = 0; i < WIDTH; i++) begin
         case (bus.fun[2*i +: 2])
            2'd1: begin
               bus.pad_oe[i]  = 1'b1;
               bus.pad_out[i] = out_q[i];
            end
            2'd2: bus.alt_in[i] = filt_q[i];
            2'd3: begin
               bus.pad_oe[i]  = 1'b1;
               bus.pad_out[i] = bus.alt_out[i];
            end
            default: ;
         endcase
      end
   end

   assign bus.in_data     = filt_q;
   assign bus.out_data    = out_q;
   assign bus.irq_pending = pend_q;
   assign bus.irq         = |pend_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpio_port_ctrl
// Brief   : Directed + randomized bench for gpio_port_ctrl with a cycle model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpio_port_ctrl;
   localparam int W   = 8;
   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   gpio_port_ctrl_if #(.WIDTH(W)) bus_if ();

   gpio_port_ctrl #(.WIDTH(W), .DEB_CYCLES(DEB), .INIT_LEVEL(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Reference: a pin's level is the pad value seen two clocks late; the
   // reported level flips once that value has disagreed for DEB clocks.
   logic [W-1:0] pad_hist [2];
   logic [W-1:0] m_level, m_pend, m_out;
   int           m_disagree [W];

   task automatic model_reset();
      pad_hist[0] = '1;
      pad_hist[1] = '1;
      m_level = '1;
      m_pend  = '0;
      m_out   = '0;
      for (int i = 0; i < W; i++) m_disagree[i] = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      logic [W-1:0] seen, events;
      int f, m;
      seen   = pad_hist[1];
      events = '0;
      @(posedge clk);
      for (int i = 0; i < W; i++) begin
         if (seen[i] == m_level[i]) begin
            m_disagree[i] = 0;
         end else begin
            m_disagree[i] = m_disagree[i] + 1;
            if (m_disagree[i] >= DEB) begin
               m_level[i]    = seen[i];
               m_disagree[i] = 0;
               f = int'(bus_if.fun[2*i +: 2]);
               m = int'(bus_if.irq_mode[2*i +: 2]);
               if ((f == 0 || f == 2) &&
                   (( seen[i] && (m == 1 || m == 3)) ||
                    (!seen[i] && (m == 2 || m == 3))))
                  events[i] = 1'b1;
            end
         end
      end
      m_pend = (m_pend & ~bus_if.irq_clr) | events;
      pad_hist[1] = pad_hist[0];
      pad_hist[0] = bus_if.pad_in;
      if (bus_if.out_wr) m_out = bus_if.out_wdata;
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [W-1:0] e_oe, e_out, e_alt;
      int f;
      for (int i = 0; i < W; i++) begin
         f = int'(bus_if.fun[2*i +: 2]);
         e_oe[i]  = (f == 1 || f == 3);
         e_out[i] = (f == 1) ? m_out[i] : (f == 3) ? bus_if.alt_out[i] : 1'b0;
         e_alt[i] = (f == 2) ? m_level[i] : 1'b1;
      end
      chk({tag, ".in_data"},  bus_if.in_data,     m_level);
      chk({tag, ".pending"},  bus_if.irq_pending, m_pend);
      chk({tag, ".irq"},      bus_if.irq,         |m_pend);
      chk({tag, ".out_data"}, bus_if.out_data,    m_out);
      chk({tag, ".pad_oe"},   bus_if.pad_oe,      e_oe);
      chk({tag, ".pad_out"},  bus_if.pad_out,     e_out);
      chk({tag, ".alt_in"},   bus_if.alt_in,      e_alt);
   endtask

   task automatic run(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         tick();
         check_all(tag);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.fun       = '0;
      bus_if.out_wr    = 1'b0;
      bus_if.out_wdata = '0;
      bus_if.pad_in    = 8'hFF;
      bus_if.alt_out   = '0;
      bus_if.irq_mode  = '0;
      bus_if.irq_clr   = '0;
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst.in_data",  bus_if.in_data, 8'hFF);
      chk("rst.pending",  bus_if.irq_pending, 8'h00);
      chk("rst.irq",      bus_if.irq, 1'b0);
      chk("rst.out_data", bus_if.out_data, 8'h00);
      chk("rst.pad_oe",   bus_if.pad_oe, 8'h00);
      run(3, "idle");

      // Pin 0 falling edge with fall interrupt, latency edge 6.
      bus_if.irq_mode[1:0] = 2'd2;
      bus_if.pad_in[0]     = 1'b0;
      run(5, "fall_wait");
      chk("fall.pre_in0", bus_if.in_data[0], 1'b1);
      run(1, "fall");
      chk("fall.in0",   bus_if.in_data[0], 1'b0);
      chk("fall.pend0", bus_if.irq_pending[0], 1'b1);
      chk("fall.irq",   bus_if.irq, 1'b1);
      bus_if.irq_clr[0] = 1'b1;
      run(1, "clr0");
      bus_if.irq_clr[0] = 1'b0;
      chk("clr0.pend0", bus_if.irq_pending[0], 1'b0);

      // Pin 1 glitch of 3 cycles is rejected, 6 cycle hold is accepted.
      bus_if.irq_mode[3:2] = 2'd3;
      bus_if.pad_in[1] = 1'b0;
      run(3, "glitch");
      bus_if.pad_in[1] = 1'b1;
      run(8, "glitch_after");
      chk("glitch.in1",   bus_if.in_data[1], 1'b1);
      chk("glitch.pend1", bus_if.irq_pending[1], 1'b0);
      bus_if.pad_in[1] = 1'b0;
      run(6, "hold");
      chk("hold.in1", bus_if.in_data[1], 1'b0);

      // Pin 2 rise lands on the same edge as its clear: set wins.
      bus_if.irq_mode[5:4] = 2'd1;
      bus_if.pad_in[2] = 1'b0;
      run(8, "p2_low");
      bus_if.pad_in[2]  = 1'b1;
      bus_if.irq_clr[2] = 1'b1;
      for (int k = 0; k < 10 && !m_level[2]; k++) run(1, "p2_rise");
      chk("simul.in2",   bus_if.in_data[2], 1'b1);
      chk("simul.pend2", bus_if.irq_pending[2], 1'b1);
      run(1, "p2_clr");
      bus_if.irq_clr[2] = 1'b0;
      chk("simul.clr2", bus_if.irq_pending[2], 1'b0);

      // Function mux.
      bus_if.irq_clr   = 8'hFF;
      run(1, "clr_all");
      bus_if.irq_clr   = '0;
      bus_if.fun       = 16'h00E4;
      bus_if.out_wr    = 1'b1;
      bus_if.out_wdata = 8'h02;
      bus_if.alt_out   = 8'h08;
      bus_if.pad_in[2] = 1'b0;
      run(1, "mux_wr");
      bus_if.out_wr = 1'b0;
      run(8, "mux");
      chk("mux.pad_oe",  bus_if.pad_oe, 8'h0A);
      chk("mux.pad_out", bus_if.pad_out, 8'h0A);
      chk("mux.alt_in",  bus_if.alt_in, 8'hFB);

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(19) == 0) bus_if.fun = 16'($urandom);
         if ($urandom_range(19) == 0) bus_if.irq_mode = 16'($urandom);
         for (int i = 0; i < W; i++)
            if ($urandom_range(5) == 0) bus_if.pad_in[i] = ~bus_if.pad_in[i];
         bus_if.irq_clr   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
         bus_if.out_wr    = ($urandom_range(7) == 0);
         bus_if.out_wdata = 8'($urandom);
         bus_if.alt_out   = 8'($urandom);
         run(1, "rand");
      end

      // Async reset mid-debounce with pending and out_data populated.
      bus_if.fun      = '0;
      bus_if.irq_mode = 16'hFFFF;
      bus_if.irq_clr  = '0;
      bus_if.out_wr   = 1'b1;
      bus_if.out_wdata = 8'h5A;
      bus_if.pad_in[0] = ~bus_if.pad_in[0];
      run(1, "ar_wr");
      bus_if.out_wr = 1'b0;
      run(8, "ar_settle");
      chk("ar.pre_out",  bus_if.out_data, 8'h5A);
      chk("ar.pre_pend0", bus_if.irq_pending[0], 1'b1);
      bus_if.pad_in[1] = ~bus_if.pad_in[1];
      run(3, "ar_mid");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("ar.out_data", bus_if.out_data, 8'h00);
      chk("ar.pending",  bus_if.irq_pending, 8'h00);
      chk("ar.irq",      bus_if.irq, 1'b0);
      chk("ar.in_data",  bus_if.in_data, 8'hFF);
      chk("ar.pad_oe",   bus_if.pad_oe, 8'h00);
      chk("ar.alt_in",   bus_if.alt_in, 8'hFF);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("ar_hold");
      run(10, "ar_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gpio_port_ctrl.md
Name: gpio_port_ctrl

Overview:
- Parametrised multi-pin GPIO port controller. Successor to the single-pin tri-buffer mux.
- Each pin independently selects one of four functions: input, output, alternate-in (e.g. UART RX) or alternate-out (e.g. UART TX).
- Adds a 2-flop input synchroniser, a per-pin debounce filter, an output data register and per-pin edge-detect interrupts with write-1-to-clear pending bits.
- Sits between the pad ring (split in/out/oe; tristate lives in the pad cell) and the MCU bus/peripherals.

Parameters:
- WIDTH, 8, number of pins.
- DEB_CYCLES, 4, consecutive stable cycles required before the filtered input changes; legal range >= 1.
- INIT_LEVEL, 1'b1, reset value of the synchroniser and filter stages for every pin.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- fun  input  2*WIDTH  per-pin function: 0 = input, 1 = output, 2 = alt-in, 3 = alt-out; bits [2i+1:2i] belong to pin i.
- out_wr  input  1  write strobe for the output register.
- out_wdata  input  WIDTH  output register write data.
- out_data  output  WIDTH  output register readback.
- in_data  output  WIDTH  debounced pin levels.
- pad_in  input  WIDTH  raw asynchronous pad inputs.
- pad_out  output  WIDTH  pad output drive values.
- pad_oe  output  WIDTH  pad output enables.
- alt_out  input  WIDTH  peripheral drive values (e.g. uart_TX).
- alt_in  output  WIDTH  peripheral receive values (e.g. uart_RX).
- irq_mode  input  2*WIDTH  per-pin interrupt mode: 0 = off, 1 = rise, 2 = fall, 3 = both.
- irq_clr  input  WIDTH  write-1-to-clear pulse for pending bits.
- irq_pending  output  WIDTH  latched edge events.
- irq  output  1  OR of irq_pending.

Behaviour:
- Reset (async, immediate, including mid-operation):
  - out_data = 0, irq_pending = 0, irq = 0.
  - Synchroniser stages and filter = INIT_LEVEL, so in_data = {WIDTH{INIT_LEVEL}}.
  - Debounce counters = 0.
- Synchroniser: s1 <= pad_in, s2 <= s1, per pin, every cycle regardless of fun.
- Debounce, per pin:
  - cnt width is clog2(DEB_CYCLES+1).
  - If s2 == filt, then cnt <= 0.
  - Else if cnt == DEB_CYCLES-1, then filt <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - in_data = filt.
  - Latency: a pad change stable before edge 1 appears on in_data after edge 2+DEB_CYCLES (edge 6 at default).
  - Any s2 mismatch lasting fewer than DEB_CYCLES cycles is rejected and produces no irq.
- Edge detect and pending:
  - An event is a filt update on a pin whose fun is 0 or 2.
  - A 0->1 update is a rise; a 1->0 update is a fall.
  - An event matching irq_mode sets irq_pending[i] on the same edge that filt updates.
  - Pins with fun 1 or 3 never set pending; their filter still runs.
  - irq_clr[i] = 1 clears the bit on the next edge. If set and clear occur in the same cycle, set wins.
  - Changing irq_mode or fun does not clear pending bits.
  - irq is combinational: |irq_pending.
- Output register: on the clock edge with out_wr = 1, out_data <= out_wdata (full word, no partial write).
- Pad mux, combinational per pin:
  - fun 0: pad_oe = 0, pad_out = 0.
  - fun 1: pad_oe = 1, pad_out = out_data[i].
  - fun 2: pad_oe = 0, pad_out = 0.
  - fun 3: pad_oe = 1, pad_out = alt_out[i].
- Alternate input:
  - alt_in[i] = in_data[i] when fun = 2.
  - Otherwise alt_in[i] = 1 (UART idle-high).
- A fun change takes effect combinationally on pad_oe, pad_out and alt_in; there is no glitch protection beyond the fun source being registered.

Test Plan:
- Reset then release, all pins fun = 0, pad_in = 8'hFF, DEB_CYCLES = 4 -> in_data = 8'hFF, irq_pending = 0, irq = 0, out_data = 0, pad_oe = 0.
- Pin 0 fun = 0, irq_mode = 2 (fall), pad_in[0] goes 1->0 before edge 1 and is held -> in_data[0] = 0 and irq_pending[0] = 1 after edge 6; irq = 1. Then irq_clr[0] pulse -> pending 0 next edge.
- Pin 1 glitch: pad_in[1] low for 3 cycles, then high -> in_data[1] stays 1 and no pending. Then hold low for 4+ cycles -> in_data[1] = 0.
- Simultaneous: irq_clr[2] asserted on the same edge a rise event on pin 2 (mode 1) lands -> irq_pending[2] = 1.
- Output/alt mux: fun = {pin3: 3, pin2: 2, pin1: 1, pin0: 0}, out_wr with 8'h02, alt_out[3] = 1, settled pad_in[2] = 0 -> pad_oe = 8'h0A, pad_out = 8'h0A, alt_in[2] = 0, other alt_in = 1.
- Async reset asserted mid-debounce with pending set and out_data = 8'h5A -> all outputs return to reset values immediately, without waiting for a clock edge.
